// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback stage of the MIPS core.
// Latches MEM-stage results, extracts little-endian load data and drives the
// register-file write port (We/A3/WD) purely from registered state.
// Optional feature macro: WB_RETIRE_CNT_EN (retired-instruction counter).
module mem_wb_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             MemValid,
  input  logic             MemRegWr,
  input  logic [4:0]       MemWA,
  input  logic [DW-1:0]    MemAlu,
  input  logic [DW-1:0]    MemRData,
  input  logic [DW-1:0]    MemPC8,
  input  logic [1:0]       MemWbSel,
  input  logic [2:0]       MemLdType,
  output logic             We,
  output logic [4:0]       A3,
  output logic [DW-1:0]    WD,
  output logic             WbValid,
  output logic [CNT_W-1:0] RetireCnt
);

  logic          valid;
  logic          regwr;
  logic [4:0]    wa;
  logic [DW-1:0] alu;
  logic [DW-1:0] rdata;
  logic [DW-1:0] pc8;
  logic [1:0]    wbsel;
  logic [2:0]    ldtype;
  logic [1:0]    addrlo;

  logic [7:0]    byteval;
  logic [15:0]   halfval;
  logic [DW-1:0] loaddata;
  logic [DW-1:0] wbdata;

  // Stage register: reset clears everything, a flush inserts a bubble (and
  // beats a stall), a stall holds the occupant, otherwise capture MEM results.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid  <= 1'b0;
      regwr  <= 1'b0;
      wa     <= '0;
      alu    <= '0;
      rdata  <= '0;
      pc8    <= '0;
      wbsel  <= '0;
      ldtype <= '0;
      addrlo <= '0;
    end else if (Flush) begin
      valid  <= 1'b0;
    end else if (!Stall) begin
      valid  <= MemValid;
      regwr  <= MemRegWr;
      wa     <= MemWA;
      alu    <= MemAlu;
      rdata  <= MemRData;
      pc8    <= MemPC8;
      wbsel  <= MemWbSel;
      ldtype <= MemLdType;
      addrlo <= MemAlu[1:0];
    end
  end

  // Pick the addressed byte/halfword and sign- or zero-extend it by load type;
  // the halfword ignores addrlo[0] since misalignment is trapped upstream.
  always_comb begin
    byteval  = 8'h00;
    halfval  = addrlo[1] ? rdata[31:16] : rdata[15:0];
    loaddata = rdata;
    case (addrlo)
      2'd0:    byteval = rdata[7:0];
      2'd1:    byteval = rdata[15:8];
      2'd2:    byteval = rdata[23:16];
      default: byteval = rdata[31:24];
    endcase
    case (ldtype)
      3'd1:    loaddata = {{(DW-8){byteval[7]}}, byteval};
      3'd2:    loaddata = {{(DW-8){1'b0}}, byteval};
      3'd3:    loaddata = {{(DW-16){halfval[15]}}, halfval};
      3'd4:    loaddata = {{(DW-16){1'b0}}, halfval};
      default: loaddata = rdata;
    endcase
  end

  // Writeback source select and RF write port; a bubble drives a quiet port,
  // and writes to $0 are suppressed while A3 still reports the field.
  always_comb begin
    wbdata = alu;
    case (wbsel)
      2'd1:    wbdata = loaddata;
      2'd2:    wbdata = pc8;
      default: wbdata = alu;
    endcase
    WbValid = valid;
    We      = valid & regwr & (wa != 5'd0);
    A3      = valid ? wa : 5'd0;
    WD      = valid ? wbdata : '0;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retirecnt;

  // Count the WB occupant when it leaves the stage: any non-reset edge that
  // is not stalled, including flush edges (a flush only kills the incoming slot).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      retirecnt <= '0;
    end else if (valid && !Stall) begin
      retirecnt <= retirecnt + CNT_W'(1);
`ifndef SYNTHESIS
      if (We) begin
        $display("%5d:[%m] retire wa=%d wd=%h", $time, wa, WD);
      end
`endif
    end
  end

  assign RetireCnt = retirecnt;
`else
  assign RetireCnt = '0;
`endif

endmodule
